// File: rtl/config_loader.sv
// rtl/config_loader.sv - serial configuration bitstream loader for tile configuration registers
//
// Assembles a serial bitstream (MSB first) into 32-bit words. A frame is one header
// word {sync 8'hA5, start target T, payload count N} followed by N payload words.
// Each payload word is broadcast on config_data with a one-hot config_en strobe
// for its target tile; the target pointer starts at T and increments per word.
//
// Optional build macro: CONFIG_LOADER_PARITY_EN
//   When defined, every word carries a 33rd bit: even parity over the 32 data bits.
//   A bad header parity drops the header; a bad payload parity suppresses that
//   word's strobe but still consumes its target slot.
//
// Parameters:
//   NUM_TARGETS    number of tile configuration registers (1..256)
// Ports:
//   clk            clock, all state updates on rising edge
//   reset          synchronous active-high reset
//   cfg_bit        serial configuration bit
//   cfg_bit_valid  cfg_bit is valid; accepted when cfg_bit_valid && cfg_ready
//   cfg_ready      loader can accept a bit this cycle (low while issuing a word)
//   config_data    last issued payload word, broadcast to all tiles
//   config_en      one-hot, one-cycle write strobe per tile
//   load_done      one-cycle pulse at end of a frame
//   frame_error    sticky error flag, cleared only by reset

module config_loader #(
  parameter int NUM_TARGETS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_bit,
  input  logic                   cfg_bit_valid,
  output logic                   cfg_ready,
  output logic [31:0]            config_data,
  output logic [NUM_TARGETS-1:0] config_en,
  output logic                   load_done,
  output logic                   frame_error
);

`ifdef CONFIG_LOADER_PARITY_EN
  localparam int WORD_BITS = 33;
  localparam int CNT_W     = 6;
`else
  localparam int WORD_BITS = 32;
  localparam int CNT_W     = 5;
`endif

  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [1:0] {
    HEADER  = 2'd0,
    PAYLOAD = 2'd1,
    ISSUE   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WORD_BITS-2:0]   shift_q, shift_d;
  logic [7:0]             ptr_q, ptr_d;
  logic [15:0]            rem_q, rem_d;

  logic                   cfg_ready_d;
  logic [31:0]            config_data_d;
  logic [NUM_TARGETS-1:0] config_en_d;
  logic                   load_done_d;
  logic                   frame_error_d;

  logic                   accept;
  logic                   word_last;
  logic [WORD_BITS-1:0]   word_full;
  logic [31:0]            data_word;
  logic                   parity_ok;
  logic                   in_range;

  assign accept    = cfg_bit_valid && cfg_ready;
  assign word_last = accept && (bit_cnt_q == CNT_W'(WORD_BITS - 1));
  // The final bit is taken straight from the input so the completed word is
  // available in the same cycle it is accepted.
  assign word_full = {shift_q, cfg_bit};
  assign data_word = word_full[WORD_BITS-1 -: 32];

`ifdef CONFIG_LOADER_PARITY_EN
  // Even parity: the 33 bits together carry an even number of ones.
  assign parity_ok = ~^word_full;
`else
  assign parity_ok = 1'b1;
`endif

  assign in_range = ({1'b0, ptr_q} < 9'(NUM_TARGETS));

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    ptr_d         = ptr_q;
    rem_d         = rem_q;
    config_data_d = config_data;
    config_en_d   = '0;
    load_done_d   = 1'b0;
    frame_error_d = frame_error;

    if (accept) begin
      shift_d   = word_full[WORD_BITS-2:0];
      bit_cnt_d = word_last ? '0 : bit_cnt_q + 1'b1;
    end

    case (state_q)
      HEADER: begin
        if (word_last) begin
          if (!parity_ok || (data_word[31:24] != SYNC)) begin
            frame_error_d = 1'b1;
          end else if (data_word[15:0] == 16'd0) begin
            load_done_d = 1'b1;
          end else begin
            state_d = PAYLOAD;
            ptr_d   = data_word[23:16];
            rem_d   = data_word[15:0];
          end
        end
      end

      PAYLOAD: begin
        // Outputs are registered, so the ISSUE-cycle values are loaded on the
        // edge that accepts the last payload bit.
        if (word_last) begin
          state_d       = ISSUE;
          config_data_d = data_word;
          load_done_d   = (rem_q == 16'd1);
          if (parity_ok && in_range) begin
            for (int i = 0; i < NUM_TARGETS; i++) begin
              config_en_d[i] = (ptr_q == 8'(i));
            end
          end else begin
            frame_error_d = 1'b1;
          end
        end
      end

      ISSUE: begin
        ptr_d   = ptr_q + 8'd1;
        rem_d   = rem_q - 16'd1;
        state_d = (rem_q > 16'd1) ? PAYLOAD : HEADER;
      end

      default: begin
        state_d = HEADER;
      end
    endcase

    cfg_ready_d = (state_d != ISSUE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HEADER;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      rem_q       <= '0;
      cfg_ready   <= 1'b0;
      config_data <= 32'h0;
      config_en   <= '0;
      load_done   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      cfg_ready   <= cfg_ready_d;
      config_data <= config_data_d;
      config_en   <= config_en_d;
      load_done   <= load_done_d;
      frame_error <= frame_error_d;
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - self-checking testbench for config_loader

module tb_config_loader;

  localparam int NT = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_bit;
  logic          cfg_bit_valid;
  logic          cfg_ready;
  logic [31:0]   config_data;
  logic [NT-1:0] config_en;
  logic          load_done;
  logic          frame_error;

  int checks = 0;
  int errors = 0;

  config_loader #(.NUM_TARGETS(NT)) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_bit       (cfg_bit),
    .cfg_bit_valid (cfg_bit_valid),
    .cfg_ready     (cfg_ready),
    .config_data   (config_data),
    .config_en     (config_en),
    .load_done     (load_done),
    .frame_error   (frame_error)
  );

  always #5 clk = ~clk;

  // Observations, sampled on the falling edge.
  logic [NT-1:0] obs_en[$];
  logic [31:0]   obs_data[$];
  int            done_cnt  = 0;
  int            ready_low = 0;
  int            bad_ready = 0;
  bit            prev_rst  = 1'b1;

  always @(negedge clk) begin
    if (config_en != '0) begin
      obs_en.push_back(config_en);
      obs_data.push_back(config_data);
      if (cfg_ready) bad_ready++;
    end
    if (load_done) done_cnt++;
    if (!reset && !prev_rst && !cfg_ready) ready_low++;
    prev_rst = reset;
  end

  // Reference model state.
  logic [NT-1:0] exp_en[$];
  logic [31:0]   exp_data[$];
  int            exp_done;
  int            exp_issue;
  logic          exp_err;
  logic [31:0]   pay_q[$];
  bit            bad_q[$];
  int            b_en, b_done, b_low, b_bad;

  // A frame's effect: each payload word k goes to tile (T+k) mod 256 if that tile
  // exists and its parity is good, otherwise it only raises the error flag.
  task automatic model_frame(input logic [31:0] hdr, input bit hdr_bad);
    int n, t, tgt;
    logic [NT-1:0] e;
    if (hdr[31:24] != 8'hA5 || hdr_bad) begin
      exp_err = 1'b1;
      return;
    end
    n = int'(hdr[15:0]);
    t = int'(hdr[23:16]);
    for (int k = 0; k < n; k++) begin
      tgt = (t + k) % 256;
      if (bad_q[k]) exp_err = 1'b1;
      else if (tgt < NT) begin
        e = '0;
        e[tgt] = 1'b1;
        exp_en.push_back(e);
        exp_data.push_back(pay_q[k]);
      end else exp_err = 1'b1;
    end
    exp_done++;
    exp_issue += n;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cfg_bit_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic begin_test();
    exp_en.delete();
    exp_data.delete();
    pay_q.delete();
    bad_q.delete();
    exp_done = 0;
    exp_issue = 0;
    exp_err = 1'b0;
    apply_reset();
    b_en = obs_en.size();
    b_done = done_cnt;
    b_low = ready_low;
    b_bad = bad_ready;
  endtask

  task automatic send_bit(input logic b, input int pct);
    bit acc = 1'b0;
    bit r;
    int g = 0;
    while ($urandom_range(0, 99) < pct && g < 20) begin
      cfg_bit_valid = 1'b0;
      cfg_bit = 1'($urandom);
      @(posedge clk);
      #1;
      g++;
    end
    cfg_bit = b;
    cfg_bit_valid = 1'b1;
    for (int c = 0; c < 200 && !acc; c++) begin
      r = cfg_ready;
      @(posedge clk);
      #1;
      if (r) acc = 1'b1;
    end
    cfg_bit_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_bit timeout cfg_ready=%b required 1 within 200 cycles", cfg_ready);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit flip, input int pct);
    for (int i = 31; i >= 0; i--) send_bit(w[i], pct);
`ifdef CONFIG_LOADER_PARITY_EN
    send_bit((^w) ^ flip, pct);
`else
    if (flip) send_bit(1'b0, pct);
`endif
  endtask

  task automatic send_frame(input logic [31:0] hdr, input bit hdr_bad, input int pct);
    send_word(hdr, hdr_bad, pct);
    for (int k = 0; k < pay_q.size(); k++) send_word(pay_q[k], bad_q[k], pct);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cfg_bit_valid = 1'b0;
    cfg_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset cfg_ready got %b required 0", cfg_ready); end
    checks++; if (config_data !== 32'h0) begin errors++; $display("FAIL reset config_data got %h required 0", config_data); end
    checks++; if (config_en !== '0) begin errors++; $display("FAIL reset config_en got %h required 0", config_en); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset load_done got %b required 0", load_done); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset frame_error got %b required 0", frame_error); end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_release cfg_ready got %b required 1", cfg_ready); end
  endtask

  task automatic test_basic();
    begin_test();
    pay_q = '{32'h1234_5678, 32'hDEAD_BEEF};
    bad_q = '{1'b0, 1'b0};
    model_frame(32'hA503_0002, 1'b0);
    send_word(32'hA503_0002, 1'b0, 0);
    send_word(32'h1234_5678, 1'b0, 0);
    checks++;
    if (config_en !== 16'h0008 || config_data !== 32'h1234_5678 || load_done !== 1'b0 || cfg_ready !== 1'b0) begin
      errors++; $display("FAIL basic word0 latency got en=%h data=%h done=%b rdy=%b required en=0008 data=12345678 done=0 rdy=0", config_en, config_data, load_done, cfg_ready);
    end
    send_word(32'hDEAD_BEEF, 1'b0, 0);
    checks++;
    if (config_en !== 16'h0010 || config_data !== 32'hDEAD_BEEF || load_done !== 1'b1) begin
      errors++; $display("FAIL basic word1 latency got en=%h data=%h done=%b required en=0010 data=deadbeef done=1", config_en, config_data, load_done);
    end
    @(posedge clk); #1;
    checks++;
    if (config_en !== '0 || config_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL basic hold got en=%h data=%h required en=0000 data=deadbeef", config_en, config_data);
    end
    repeat (6) @(posedge clk); #1;
    checks++;
    if (obs_en.size() - b_en !== exp_en.size()) begin errors++; $display("FAIL basic strobe count got %0d required %0d", obs_en.size() - b_en, exp_en.size()); end
    else for (int i = 0; i < exp_en.size(); i++) begin
      checks++;
      if (obs_en[b_en+i] !== exp_en[i] || obs_data[b_en+i] !== exp_data[i]) begin errors++; $display("FAIL basic strobe %0d got en=%h data=%h required en=%h data=%h", i, obs_en[b_en+i], obs_data[b_en+i], exp_en[i], exp_data[i]); end
    end
    checks++; if (done_cnt - b_done !== exp_done) begin errors++; $display("FAIL basic load_done count got %0d required %0d", done_cnt - b_done, exp_done); end
    checks++; if (frame_error !== exp_err) begin errors++; $display("FAIL basic frame_error got %b required %b", frame_error, exp_err); end
  endtask

  task automatic test_bad_sync();
    begin_test();
    model_frame(32'h5A00_0001, 1'b0);
    send_word(32'h5A00_0001, 1'b0, 0);
    checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL bad_sync frame_error got %b required 1", frame_error); end
    pay_q = '{32'($urandom)};
    bad_q = '{1'b0};
    model_frame(32'hA500_0001, 1'b0);
    send_frame(32'hA500_0001, 1'b0, 0);
    repeat (6) @(posedge clk); #1;
    checks++;
    if (obs_en.size() - b_en !== exp_en.size()) begin errors++; $display("FAIL bad_sync strobe count got %0d required %0d", obs_en.size() - b_en, exp_en.size()); end
    else for (int i = 0; i < exp_en.size(); i++) begin
      checks++;
      if (obs_en[b_en+i] !== exp_en[i] || obs_data[b_en+i] !== exp_data[i]) begin errors++; $display("FAIL bad_sync strobe %0d got en=%h data=%h required en=%h data=%h", i, obs_en[b_en+i], obs_data[b_en+i], exp_en[i], exp_data[i]); end
    end
    checks++; if (done_cnt - b_done !== exp_done) begin errors++; $display("FAIL bad_sync load_done count got %0d required %0d", done_cnt - b_done, exp_done); end
    checks++; if (frame_error !== exp_err) begin errors++; $display("FAIL bad_sync frame_error got %b required %b", frame_error, exp_err); end
  endtask

  task automatic test_out_of_range();
    begin_test();
    pay_q = '{32'($urandom), 32'($urandom)};
    bad_q = '{1'b0, 1'b0};
    model_frame(32'hA50F_0002, 1'b0);
    send_frame(32'hA50F_0002, 1'b0, 0);
    repeat (6) @(posedge clk); #1;
    checks++;
    if (obs_en.size() - b_en !== exp_en.size()) begin errors++; $display("FAIL out_of_range strobe count got %0d required %0d", obs_en.size() - b_en, exp_en.size()); end
    else for (int i = 0; i < exp_en.size(); i++) begin
      checks++;
      if (obs_en[b_en+i] !== exp_en[i] || obs_data[b_en+i] !== exp_data[i]) begin errors++; $display("FAIL out_of_range strobe %0d got en=%h data=%h required en=%h data=%h", i, obs_en[b_en+i], obs_data[b_en+i], exp_en[i], exp_data[i]); end
    end
    checks++; if (done_cnt - b_done !== exp_done) begin errors++; $display("FAIL out_of_range load_done count got %0d required %0d", done_cnt - b_done, exp_done); end
    checks++; if (frame_error !== exp_err) begin errors++; $display("FAIL out_of_range frame_error got %b required %b", frame_error, exp_err); end
  endtask

  task automatic test_zero_count();
    begin_test();
    model_frame(32'hA502_0000, 1'b0);
    send_word(32'hA502_0000, 1'b0, 0);
    checks++;
    if (load_done !== 1'b1 || config_en !== '0 || cfg_ready !== 1'b1) begin
      errors++; $display("FAIL zero_count pulse got done=%b en=%h rdy=%b required done=1 en=0000 rdy=1", load_done, config_en, cfg_ready);
    end
    pay_q = '{32'($urandom)};
    bad_q = '{1'b0};
    model_frame(32'hA507_0001, 1'b0);
    send_frame(32'hA507_0001, 1'b0, 0);
    repeat (6) @(posedge clk); #1;
    checks++;
    if (obs_en.size() - b_en !== exp_en.size()) begin errors++; $display("FAIL zero_count strobe count got %0d required %0d", obs_en.size() - b_en, exp_en.size()); end
    else for (int i = 0; i < exp_en.size(); i++) begin
      checks++;
      if (obs_en[b_en+i] !== exp_en[i] || obs_data[b_en+i] !== exp_data[i]) begin errors++; $display("FAIL zero_count strobe %0d got en=%h data=%h required en=%h data=%h", i, obs_en[b_en+i], obs_data[b_en+i], exp_en[i], exp_data[i]); end
    end
    checks++; if (done_cnt - b_done !== exp_done) begin errors++; $display("FAIL zero_count load_done count got %0d required %0d", done_cnt - b_done, exp_done); end
    checks++; if (frame_error !== exp_err) begin errors++; $display("FAIL zero_count frame_error got %b required %b", frame_error, exp_err); end
  endtask

  task automatic test_random_gaps();
    logic [31:0] hdr;
    int n;
    begin_test();
    for (int f = 0; f < 4; f++) begin
      n = int'($urandom_range(1, 4));
      hdr = {8'hA5, 8'($urandom_range(0, 19)), 16'(n)};
      pay_q.delete();
      bad_q.delete();
      for (int k = 0; k < n; k++) begin
        pay_q.push_back(32'($urandom));
        bad_q.push_back(1'b0);
      end
      model_frame(hdr, 1'b0);
      send_frame(hdr, 1'b0, 50);
    end
    repeat (6) @(posedge clk); #1;
    checks++;
    if (obs_en.size() - b_en !== exp_en.size()) begin errors++; $display("FAIL random_gaps strobe count got %0d required %0d", obs_en.size() - b_en, exp_en.size()); end
    else for (int i = 0; i < exp_en.size(); i++) begin
      checks++;
      if (obs_en[b_en+i] !== exp_en[i] || obs_data[b_en+i] !== exp_data[i]) begin errors++; $display("FAIL random_gaps strobe %0d got en=%h data=%h required en=%h data=%h", i, obs_en[b_en+i], obs_data[b_en+i], exp_en[i], exp_data[i]); end
    end
    checks++; if (done_cnt - b_done !== exp_done) begin errors++; $display("FAIL random_gaps load_done count got %0d required %0d", done_cnt - b_done, exp_done); end
    checks++; if (frame_error !== exp_err) begin errors++; $display("FAIL random_gaps frame_error got %b required %b", frame_error, exp_err); end
    checks++; if (ready_low - b_low !== exp_issue) begin errors++; $display("FAIL random_gaps cfg_ready low cycles got %0d required %0d", ready_low - b_low, exp_issue); end
    checks++; if (bad_ready - b_bad !== 0) begin errors++; $display("FAIL random_gaps cfg_ready high during strobe got %0d required 0", bad_ready - b_bad); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] hdrs[5];
    int n;
    begin_test();
    hdrs = '{32'hA5FF_0003, 32'hA50E_0004, 32'hA500_0001, 32'hA509_0000, 32'hA50B_0002};
    for (int f = 0; f < 5; f++) begin
      n = int'(hdrs[f][15:0]);
      pay_q.delete();
      bad_q.delete();
      for (int k = 0; k < n; k++) begin
        pay_q.push_back(32'($urandom));
        bad_q.push_back(1'b0);
      end
      model_frame(hdrs[f], 1'b0);
      send_frame(hdrs[f], 1'b0, 0);
    end
    repeat (6) @(posedge clk); #1;
    checks++;
    if (obs_en.size() - b_en !== exp_en.size()) begin errors++; $display("FAIL back_to_back strobe count got %0d required %0d", obs_en.size() - b_en, exp_en.size()); end
    else for (int i = 0; i < exp_en.size(); i++) begin
      checks++;
      if (obs_en[b_en+i] !== exp_en[i] || obs_data[b_en+i] !== exp_data[i]) begin errors++; $display("FAIL back_to_back strobe %0d got en=%h data=%h required en=%h data=%h", i, obs_en[b_en+i], obs_data[b_en+i], exp_en[i], exp_data[i]); end
    end
    checks++; if (done_cnt - b_done !== exp_done) begin errors++; $display("FAIL back_to_back load_done count got %0d required %0d", done_cnt - b_done, exp_done); end
    checks++; if (frame_error !== exp_err) begin errors++; $display("FAIL back_to_back frame_error got %b required %b", frame_error, exp_err); end
    checks++; if (ready_low - b_low !== exp_issue) begin errors++; $display("FAIL back_to_back cfg_ready low cycles got %0d required %0d", ready_low - b_low, exp_issue); end
  endtask

  task automatic test_mid_reset();
    begin_test();
    send_word(32'hA504_0001, 1'b0, 0);
    for (int i = 0; i < 20; i++) send_bit(1'($urandom), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (config_en !== '0 || config_data !== 32'h0 || load_done !== 1'b0 || frame_error !== 1'b0 || cfg_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset outputs got en=%h data=%h done=%b err=%b rdy=%b required all zero", config_en, config_data, load_done, frame_error, cfg_ready);
    end
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    pay_q = '{32'($urandom)};
    bad_q = '{1'b0};
    model_frame(32'hA504_0001, 1'b0);
    send_frame(32'hA504_0001, 1'b0, 0);
    repeat (6) @(posedge clk); #1;
    checks++;
    if (obs_en.size() - b_en !== exp_en.size()) begin errors++; $display("FAIL mid_reset strobe count got %0d required %0d", obs_en.size() - b_en, exp_en.size()); end
    else for (int i = 0; i < exp_en.size(); i++) begin
      checks++;
      if (obs_en[b_en+i] !== exp_en[i] || obs_data[b_en+i] !== exp_data[i]) begin errors++; $display("FAIL mid_reset strobe %0d got en=%h data=%h required en=%h data=%h", i, obs_en[b_en+i], obs_data[b_en+i], exp_en[i], exp_data[i]); end
    end
    checks++; if (done_cnt - b_done !== exp_done) begin errors++; $display("FAIL mid_reset load_done count got %0d required %0d", done_cnt - b_done, exp_done); end
    checks++; if (frame_error !== exp_err) begin errors++; $display("FAIL mid_reset frame_error got %b required %b", frame_error, exp_err); end
  endtask

`ifdef CONFIG_LOADER_PARITY_EN
  task automatic test_parity();
    begin_test();
    pay_q = '{32'($urandom), 32'($urandom), 32'($urandom)};
    bad_q = '{1'b0, 1'b1, 1'b0};
    model_frame(32'hA501_0003, 1'b0);
    send_frame(32'hA501_0003, 1'b0, 0);
    model_frame(32'hA505_0001, 1'b1);
    send_word(32'hA505_0001, 1'b1, 0);
    pay_q = '{32'($urandom)};
    bad_q = '{1'b0};
    model_frame(32'hA505_0001, 1'b0);
    send_frame(32'hA505_0001, 1'b0, 0);
    repeat (6) @(posedge clk); #1;
    checks++;
    if (obs_en.size() - b_en !== exp_en.size()) begin errors++; $display("FAIL parity strobe count got %0d required %0d", obs_en.size() - b_en, exp_en.size()); end
    else for (int i = 0; i < exp_en.size(); i++) begin
      checks++;
      if (obs_en[b_en+i] !== exp_en[i] || obs_data[b_en+i] !== exp_data[i]) begin errors++; $display("FAIL parity strobe %0d got en=%h data=%h required en=%h data=%h", i, obs_en[b_en+i], obs_data[b_en+i], exp_en[i], exp_data[i]); end
    end
    checks++; if (done_cnt - b_done !== exp_done) begin errors++; $display("FAIL parity load_done count got %0d required %0d", done_cnt - b_done, exp_done); end
    checks++; if (frame_error !== exp_err) begin errors++; $display("FAIL parity frame_error got %b required %b", frame_error, exp_err); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    cfg_bit = 1'b0;
    cfg_bit_valid = 1'b0;
    test_reset();
    test_basic();
    test_bad_sync();
    test_out_of_range();
    test_zero_count();
    test_random_gaps();
    test_back_to_back();
    test_mid_reset();
`ifdef CONFIG_LOADER_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
